// File: rtl/ghash_pkg.sv
// ============================================================================
// Module      : ghash_pkg
// Description : Shared GF(2^128) constants and GHASH FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ghash_pkg;

    localparam int GF_W = 128;

    // GCM bit order: bit 127 carries the x^0 coefficient.
    localparam logic [GF_W-1:0] GF_ZERO = '0;
    localparam logic [GF_W-1:0] GF_ONE  = {1'b1, {(GF_W-1){1'b0}}};

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t READY = 2'd1;
    localparam state_t BUSY  = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ghash_acc_if.sv
// ============================================================================
// Module      : ghash_acc_if
// Description : Key-load, block-input and tag-output signals of ghash_acc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ghash_acc_if
    import ghash_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic             h_load;
    logic [GF_W-1:0]  h_in;
    logic             blk_valid;
    logic             blk_ready;
    logic [GF_W-1:0]  blk_data;
    logic             blk_last;
    logic             tag_valid;
    logic             tag_ready;
    logic [GF_W-1:0]  tag;
    logic [CNT_W-1:0] blk_cnt;

    modport master (
        output h_load, h_in, blk_valid, blk_data, blk_last, tag_ready,
        input  blk_ready, tag_valid, tag, blk_cnt
    );

    modport slave (
        input  h_load, h_in, blk_valid, blk_data, blk_last, tag_ready,
        output blk_ready, tag_valid, tag, blk_cnt
    );

endinterface

`default_nettype wire

// File: rtl/ghash_acc_gf_mul.sv
// ============================================================================
// Module      : gf_mul_128
// Description : Combinational GF(2^128) multiply, GCM bit order, c = a * b.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_mul_128
    import ghash_pkg::*;
(
    input  wire logic [GF_W-1:0] a,
    input  wire logic [GF_W-1:0] b,
    output logic      [GF_W-1:0] c
);

    // Reduction by x^128 + x^7 + x^2 + x + 1, expressed in GCM bit order.
    localparam logic [GF_W-1:0] c_R = {8'hE1, {(GF_W-8){1'b0}}};

    logic [GF_W-1:0] w_z;
    logic [GF_W-1:0] w_v;

    always_comb begin
        w_z = '0;
        w_v = b;
        for (int i = 0; i < GF_W; i++) begin
            if (a[GF_W-1-i]) begin
                w_z = w_z ^ w_v;
            end
            w_v = w_v[0] ? ((w_v >> 1) ^ c_R) : (w_v >> 1);
        end
        c = w_z;
    end

endmodule

`default_nettype wire

// File: rtl/ghash_acc.sv
// ============================================================================
// Module      : ghash_acc
// Description : GHASH accumulator Y <= (Y ^ X) * H with tag output.
//               Define GHASH_PIPE_EN to register the multiplier inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghash_acc
    import ghash_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ghash_acc_if.slave bus
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [GF_W-1:0]  r_y;
    logic [GF_W-1:0]  r_h;
    logic [GF_W-1:0]  r_tag;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_h_load;
    logic [GF_W-1:0]  w_mul_a;
    logic [GF_W-1:0]  w_mul_b;
    logic [GF_W-1:0]  w_mul_c;

`ifdef GHASH_PIPE_EN
    logic [GF_W-1:0]  r_mul_a;
    logic [GF_W-1:0]  r_mul_b;
    logic             r_last;

    assign w_mul_a = r_mul_a;
    assign w_mul_b = r_mul_b;
`else
    assign w_mul_a = r_y ^ bus.blk_data;
    assign w_mul_b = r_h;
`endif

    // A key load in READY takes priority over a block beat in the same cycle.
    assign w_h_load = bus.h_load && ((r_state == IDLE) || (r_state == READY));
    assign w_accept = (r_state == READY) && bus.blk_valid && !bus.h_load;

    gf_mul_128 u_gf_mul (
        .a (w_mul_a),
        .b (w_mul_b),
        .c (w_mul_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_y     <= GF_ZERO;
            r_h     <= GF_ZERO;
            r_tag   <= GF_ZERO;
            r_cnt   <= '0;
`ifdef GHASH_PIPE_EN
            r_mul_a <= GF_ZERO;
            r_mul_b <= GF_ZERO;
            r_last  <= 1'b0;
`endif
        end else if (w_h_load) begin
            r_h     <= bus.h_in;
            r_y     <= GF_ZERO;
            r_cnt   <= '0;
            r_state <= READY;
        end else begin
            case (r_state)
                READY: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
`ifdef GHASH_PIPE_EN
                        r_mul_a <= r_y ^ bus.blk_data;
                        r_mul_b <= r_h;
                        r_last  <= bus.blk_last;
                        r_state <= BUSY;
`else
                        r_y <= w_mul_c;
                        if (bus.blk_last) begin
                            r_tag   <= w_mul_c;
                            r_state <= DONE;
                        end
`endif
                    end
                end
`ifdef GHASH_PIPE_EN
                BUSY: begin
                    r_y <= w_mul_c;
                    if (r_last) begin
                        r_tag   <= w_mul_c;
                        r_state <= DONE;
                    end else begin
                        r_state <= READY;
                    end
                end
`endif
                DONE: begin
                    if (bus.tag_ready) begin
                        r_y     <= GF_ZERO;
                        r_cnt   <= '0;
                        r_state <= READY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.blk_ready = (r_state == READY);
    assign bus.tag_valid = (r_state == DONE);
    assign bus.tag       = r_tag;
    assign bus.blk_cnt   = r_cnt;

endmodule

`default_nettype wire
